// File: rtl/fm_axi_wch.sv
// Bridge write-command stage: turns one split command into a single AXI INCR
// write burst and tracks outstanding bursts until their write responses return.
module fm_axi_wch #(
  parameter int P_IB_ADDR_WIDTH = 29,
  parameter int P_IB_LEN_WIDTH  = 6,
  parameter int P_IB_DATA_WIDTH = 64,
  parameter int P_MAX_OUTS      = 4
) (
  input  logic                         clk_core,
  input  logic                         rst,
  input  logic                         i_brg_req,
  input  logic [P_IB_ADDR_WIDTH-1:0]   i_brg_adrs,
  input  logic [P_IB_LEN_WIDTH-1:0]    i_brg_len,
  output logic                         o_brg_ack,
  input  logic                         i_brg_wdvalid,
  input  logic [P_IB_DATA_WIDTH-1:0]   i_brg_wdata,
  input  logic [P_IB_DATA_WIDTH/8-1:0] i_brg_be,
  output logic                         o_brg_wdack,
  output logic                         o_awvalid,
  output logic [31:0]                  o_awaddr,
  output logic [7:0]                   o_awlen,
  output logic [2:0]                   o_awsize,
  output logic [1:0]                   o_awburst,
  input  logic                         i_awready,
  output logic                         o_wvalid,
  output logic [P_IB_DATA_WIDTH-1:0]   o_wdata,
  output logic [P_IB_DATA_WIDTH/8-1:0] o_wstrb,
  output logic                         o_wlast,
  input  logic                         i_wready,
  input  logic                         i_bvalid,
  input  logic [1:0]                   i_bresp,
  output logic                         o_bready,
  output logic                         o_idle,
  output logic                         o_err
);

  localparam int OW = $clog2(P_MAX_OUTS + 1);
  localparam logic [OW-1:0]             MAX_OUTS = OW'(P_MAX_OUTS);
  localparam logic [OW-1:0]             OUTS_ONE = OW'(1);
  localparam logic [P_IB_LEN_WIDTH-1:0] LEN_ONE  = P_IB_LEN_WIDTH'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W} state_t;

  state_t                      state_q, state_d;
  logic [P_IB_ADDR_WIDTH-1:0]  adrs_q, adrs_d;
  logic [P_IB_LEN_WIDTH-1:0]   len_q, len_d;
  logic [P_IB_LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]               outs_cnt_q, outs_cnt_d;
  logic                        err_q, err_d;

  logic [P_IB_LEN_WIDTH-1:0]   len_m1;
  logic                        ack, aw_hs, b_hs;

  // A zero length is treated as a single beat.
  assign len_m1 = (len_q == '0) ? '0 : (len_q - LEN_ONE);

  always_comb begin
    state_d     = state_q;
    adrs_d      = adrs_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    ack         = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_brg_wdack = 1'b0;
    o_wlast     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_brg_req && (outs_cnt_q < MAX_OUTS)) begin
          ack        = 1'b1;
          adrs_d     = i_brg_adrs;
          len_d      = i_brg_len;
          beat_cnt_d = '0;
          state_d    = ST_AW;
        end
      end
      ST_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) state_d = ST_W;
      end
      ST_W: begin
        o_wvalid    = i_brg_wdvalid;
        o_brg_wdack = i_brg_wdvalid & i_wready;
        o_wlast     = (beat_cnt_q == len_m1);
        if (o_brg_wdack) begin
          beat_cnt_d = beat_cnt_q + LEN_ONE;
          if (o_wlast) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The request path is combinational, so keep the ack quiet while reset is held.
  assign o_brg_ack = ack & ~rst;

  assign aw_hs = o_awvalid & i_awready;
  assign b_hs  = i_bvalid & o_bready;

  always_comb begin
    outs_cnt_d = outs_cnt_q;
    case ({aw_hs, b_hs})
      2'b10:   outs_cnt_d = outs_cnt_q + OUTS_ONE;
      2'b01:   outs_cnt_d = outs_cnt_q - OUTS_ONE;
      default: outs_cnt_d = outs_cnt_q;
    endcase
    err_d = err_q | (b_hs & (i_bresp != 2'b00));
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      adrs_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      outs_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adrs_q     <= adrs_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      outs_cnt_q <= outs_cnt_d;
      err_q      <= err_d;
    end
  end

  assign o_awaddr  = 32'({adrs_q, 3'b000});
  assign o_awlen   = 8'(len_m1);
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_wdata   = i_brg_wdata;
  assign o_wstrb   = i_brg_be;
  assign o_bready  = (outs_cnt_q != '0);
  assign o_idle    = (state_q == ST_IDLE) && (outs_cnt_q == '0);
  assign o_err     = err_q;

endmodule

// File: tb/tb_fm_axi_wch.sv
// Directed bench for fm_axi_wch: single bursts, AW/W stalls, outstanding limit,
// coincident AW/B handshakes, error stickiness and mid-burst reset.
module tb_fm_axi_wch;

  logic        clk_core = 1'b0;
  logic        rst;
  logic        i_brg_req;
  logic [28:0] i_brg_adrs;
  logic [5:0]  i_brg_len;
  logic        o_brg_ack;
  logic        i_brg_wdvalid;
  logic [63:0] i_brg_wdata;
  logic [7:0]  i_brg_be;
  logic        o_brg_wdack;
  logic        o_awvalid;
  logic [31:0] o_awaddr;
  logic [7:0]  o_awlen;
  logic [2:0]  o_awsize;
  logic [1:0]  o_awburst;
  logic        i_awready;
  logic        o_wvalid;
  logic [63:0] o_wdata;
  logic [7:0]  o_wstrb;
  logic        o_wlast;
  logic        i_wready;
  logic        i_bvalid;
  logic [1:0]  i_bresp;
  logic        o_bready;
  logic        o_idle;
  logic        o_err;

  int errors = 0;
  int checks = 0;

  always #5 clk_core = ~clk_core;

  fm_axi_wch dut (
    .clk_core(clk_core), .rst(rst),
    .i_brg_req(i_brg_req), .i_brg_adrs(i_brg_adrs), .i_brg_len(i_brg_len),
    .o_brg_ack(o_brg_ack),
    .i_brg_wdvalid(i_brg_wdvalid), .i_brg_wdata(i_brg_wdata), .i_brg_be(i_brg_be),
    .o_brg_wdack(o_brg_wdack),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
    .o_awsize(o_awsize), .o_awburst(o_awburst), .i_awready(i_awready),
    .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
    .i_wready(i_wready),
    .i_bvalid(i_bvalid), .i_bresp(i_bresp), .o_bready(o_bready),
    .o_idle(o_idle), .o_err(o_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic do_b(input logic [1:0] resp);
    i_bvalid = 1'b1;
    i_bresp  = resp;
    #1;
    chk("b_bready", {63'd0, o_bready}, 64'd1);
    step();
    i_bvalid = 1'b0;
    i_bresp  = 2'b00;
  endtask

  // Full command with awready/wready high; exp_addr and exp_len are hand-computed.
  task automatic burst(input logic [28:0] adrs, input logic [5:0] len,
                       input logic [31:0] exp_addr, input logic [7:0] exp_len);
    i_brg_req  = 1'b1;
    i_brg_adrs = adrs;
    i_brg_len  = len;
    i_awready  = 1'b1;
    i_wready   = 1'b1;
    i_brg_wdvalid = 1'b1;
    #1;
    chk("burst_ack", {63'd0, o_brg_ack}, 64'd1);
    step();
    i_brg_req = 1'b0;
    #1;
    chk("burst_awvalid", {63'd0, o_awvalid}, 64'd1);
    chk("burst_awaddr", {32'd0, o_awaddr}, {32'd0, exp_addr});
    chk("burst_awlen", {56'd0, o_awlen}, {56'd0, exp_len});
    chk("burst_awsize", {61'd0, o_awsize}, 64'd3);
    chk("burst_awburst", {62'd0, o_awburst}, 64'd1);
    chk("burst_ack_aw", {63'd0, o_brg_ack}, 64'd0);
    chk("burst_wvalid_aw", {63'd0, o_wvalid}, 64'd0);
    step();
    for (int b = 0; b < int'(len); b++) begin
      i_brg_wdata = 64'hA5A5_0000_0000_0000 | 64'(b);
      i_brg_be    = 8'hF0 ^ 8'(b);
      #1;
      $display("beat %0d: wvalid=%0b wdack=%0b wlast=%0b wdata=%0h", b, o_wvalid, o_brg_wdack, o_wlast, o_wdata);
      chk("burst_wdack", {63'd0, o_brg_wdack}, 64'd1);
      chk("burst_wlast", {63'd0, o_wlast}, (b == int'(len) - 1) ? 64'd1 : 64'd0);
      chk("burst_wdata", o_wdata, 64'hA5A5_0000_0000_0000 | 64'(b));
      chk("burst_wstrb", {56'd0, o_wstrb}, {56'd0, 8'hF0 ^ 8'(b)});
      step();
    end
    i_brg_wdvalid = 1'b0;
    #1;
    chk("burst_wvalid_after", {63'd0, o_wvalid}, 64'd0);
  endtask

  bit pat_v [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  bit pat_r [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int beats;
    int pulses;
    rst = 1'b1;
    i_brg_req = 1'b1; i_brg_adrs = '0; i_brg_len = '0;
    i_brg_wdvalid = 1'b1; i_brg_wdata = '0; i_brg_be = '0;
    i_awready = 1'b0; i_wready = 1'b1; i_bvalid = 1'b0; i_bresp = 2'b00;

    // Reset state
    step();
    chk("rst_ack", {63'd0, o_brg_ack}, 64'd0);
    chk("rst_awvalid", {63'd0, o_awvalid}, 64'd0);
    chk("rst_wvalid", {63'd0, o_wvalid}, 64'd0);
    chk("rst_wlast", {63'd0, o_wlast}, 64'd0);
    chk("rst_wdack", {63'd0, o_brg_wdack}, 64'd0);
    chk("rst_bready", {63'd0, o_bready}, 64'd0);
    chk("rst_idle", {63'd0, o_idle}, 64'd1);
    chk("rst_err", {63'd0, o_err}, 64'd0);
    i_brg_req = 1'b0;
    i_brg_wdvalid = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Single 4-beat command at 0x200
    burst(29'h200, 6'd4, 32'h0000_1000, 8'd3);
    chk("t1_idle_outs", {63'd0, o_idle}, 64'd0);
    do_b(2'b00);
    #1;
    chk("t1_idle", {63'd0, o_idle}, 64'd1);
    chk("t1_err", {63'd0, o_err}, 64'd0);
    $display("t1: single burst done");

    // AW stall for 5 cycles, AW fields stable, no W beat before handshake
    i_brg_req = 1'b1; i_brg_adrs = 29'h1234567; i_brg_len = 6'd2;
    i_awready = 1'b0; i_brg_wdvalid = 1'b1; i_wready = 1'b1;
    #1;
    chk("t2_ack", {63'd0, o_brg_ack}, 64'd1);
    step();
    i_brg_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_brg_adrs = 29'(c * 29'h111);
      i_brg_len  = 6'(c + 9);
      #1;
      chk("t2_awvalid", {63'd0, o_awvalid}, 64'd1);
      chk("t2_awaddr", {32'd0, o_awaddr}, 64'h091A_2B38);
      chk("t2_awlen", {56'd0, o_awlen}, 64'd1);
      chk("t2_wvalid", {63'd0, o_wvalid}, 64'd0);
      chk("t2_wdack", {63'd0, o_brg_wdack}, 64'd0);
      step();
    end
    i_awready = 1'b1;
    #1;
    chk("t2_awvalid_hs", {63'd0, o_awvalid}, 64'd1);
    step();
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("t2_wdack_beat", {63'd0, o_brg_wdack}, 64'd1);
      chk("t2_wlast_beat", {63'd0, o_wlast}, (b == 1) ? 64'd1 : 64'd0);
      step();
    end
    do_b(2'b00);
    $display("t2: AW stall done");

    // Toggling wdvalid / wready stalls with len=3
    i_brg_req = 1'b1; i_brg_adrs = 29'h10; i_brg_len = 6'd3;
    i_brg_wdvalid = 1'b0;
    #1;
    chk("t3_ack", {63'd0, o_brg_ack}, 64'd1);
    step();
    i_brg_req = 1'b0;
    #1;
    chk("t3_awlen", {56'd0, o_awlen}, 64'd2);
    step();
    beats = 0;
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      i_brg_wdvalid = pat_v[c];
      i_wready = pat_r[c];
      #1;
      $display("t3 cycle %0d: wvalid=%0b wdack=%0b wlast=%0b", c, o_wvalid, o_brg_wdack, o_wlast);
      chk("t3_wvalid", {63'd0, o_wvalid}, {63'd0, pat_v[c]});
      chk("t3_wdack", {63'd0, o_brg_wdack}, {63'd0, pat_v[c] & pat_r[c]});
      chk("t3_wlast", {63'd0, o_wlast}, (beats == 2) ? 64'd1 : 64'd0);
      if (o_brg_wdack) pulses++;
      if (pat_v[c] && pat_r[c]) beats++;
      step();
    end
    chk("t3_pulses", 64'(pulses), 64'd3);
    i_brg_wdvalid = 1'b1;
    i_wready = 1'b1;
    #1;
    chk("t3_wvalid_idle", {63'd0, o_wvalid}, 64'd0);
    do_b(2'b00);

    // Outstanding limit: four len=1 commands accepted, fifth held
    i_awready = 1'b1; i_wready = 1'b1; i_brg_wdvalid = 1'b1; i_bvalid = 1'b0;
    i_brg_len = 6'd1;
    for (int k = 0; k < 4; k++) begin
      i_brg_req = 1'b1;
      i_brg_adrs = 29'(k);
      #1;
      chk("t4_ack", {63'd0, o_brg_ack}, 64'd1);
      step();
      i_brg_req = 1'b0;
      #1;
      chk("t4_awvalid", {63'd0, o_awvalid}, 64'd1);
      step();
      #1;
      chk("t4_wlast", {63'd0, o_wlast}, 64'd1);
      chk("t4_wdack", {63'd0, o_brg_wdack}, 64'd1);
      step();
      $display("t4: command %0d issued", k);
    end
    i_brg_req = 1'b1;
    i_brg_adrs = 29'h4;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t4_ack_held", {63'd0, o_brg_ack}, 64'd0);
      step();
    end
    i_bvalid = 1'b1;
    #1;
    chk("t4_ack_held_b", {63'd0, o_brg_ack}, 64'd0);
    step();
    i_bvalid = 1'b0;
    #1;
    chk("t4_ack_fifth", {63'd0, o_brg_ack}, 64'd1);
    step();
    i_brg_req = 1'b0;

    // AW and B handshake together with an error response
    i_bvalid = 1'b1; i_bresp = 2'b10;
    #1;
    chk("t5_awvalid", {63'd0, o_awvalid}, 64'd1);
    chk("t5_bready", {63'd0, o_bready}, 64'd1);
    step();
    i_bvalid = 1'b0; i_bresp = 2'b00;
    #1;
    chk("t5_err", {63'd0, o_err}, 64'd1);
    chk("t5_wlast", {63'd0, o_wlast}, 64'd1);
    step();
    for (int k = 0; k < 3; k++) begin
      do_b(2'b00);
      #1;
      chk("t5_err_sticky", {63'd0, o_err}, 64'd1);
    end
    #1;
    chk("t5_bready_drained", {63'd0, o_bready}, 64'd0);
    chk("t5_idle", {63'd0, o_idle}, 64'd1);
    $display("t5: outstanding count and error checked");

    // Reset mid-burst after the 2nd of 4 beats
    i_brg_req = 1'b1; i_brg_adrs = 29'h40; i_brg_len = 6'd4;
    i_brg_wdvalid = 1'b1;
    #1;
    chk("t6_ack", {63'd0, o_brg_ack}, 64'd1);
    step();
    i_brg_req = 1'b0;
    step();
    for (int b = 0; b < 2; b++) begin
      #1;
      chk("t6_wdack", {63'd0, o_brg_wdack}, 64'd1);
      step();
    end
    i_brg_req = 1'b1;
    rst = 1'b1;
    #1;
    chk("t6_rst_wvalid", {63'd0, o_wvalid}, 64'd0);
    chk("t6_rst_wlast", {63'd0, o_wlast}, 64'd0);
    chk("t6_rst_wdack", {63'd0, o_brg_wdack}, 64'd0);
    chk("t6_rst_awvalid", {63'd0, o_awvalid}, 64'd0);
    chk("t6_rst_bready", {63'd0, o_bready}, 64'd0);
    chk("t6_rst_ack", {63'd0, o_brg_ack}, 64'd0);
    chk("t6_rst_idle", {63'd0, o_idle}, 64'd1);
    chk("t6_rst_err", {63'd0, o_err}, 64'd0);
    step();
    rst = 1'b0;
    i_brg_req = 1'b0;
    #1;
    burst(29'h80, 6'd4, 32'h0000_0400, 8'd3);
    do_b(2'b00);
    #1;
    chk("t6_idle_end", {63'd0, o_idle}, 64'd1);
    chk("t6_err_end", {63'd0, o_err}, 64'd0);
    $display("t6: reset recovery done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fm_axi_wch.md
FM_AXI_WCH -- requirements
Module: fm_axi_wch

Interface
REQ-001 Parameters: P_IB_ADDR_WIDTH, default 29, bridge address in 8-byte units; P_IB_LEN_WIDTH, default 6, burst length in beats; P_IB_DATA_WIDTH, default 64, data width; P_MAX_OUTS, default 4, maximum outstanding AXI write bursts.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk_core  in  1  core clock; all state is updated on its rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 i_brg_req  in  1  write command request from the 4KB split stage.
REQ-006 i_brg_adrs  in  P_IB_ADDR_WIDTH  command start address in 8-byte units.
REQ-007 i_brg_len  in  P_IB_LEN_WIDTH  command length in beats; legal range is 1..2^P_IB_LEN_WIDTH-1.
REQ-008 o_brg_ack  out  1  command accepted; one-cycle pulse.
REQ-009 i_brg_wdvalid  in  1  write data valid.
REQ-010 i_brg_wdata  in  P_IB_DATA_WIDTH  write data.
REQ-011 i_brg_be  in  P_IB_DATA_WIDTH/8  byte enables.
REQ-012 o_brg_wdack  out  1  write data beat consumed.
REQ-013 o_awvalid, o_awaddr[31:0], o_awlen[7:0], o_awsize[2:0], o_awburst[1:0]  out  AXI write address channel; i_awready  in  1.
REQ-014 o_wvalid, o_wdata, o_wstrb, o_wlast  out  AXI write data channel; i_wready  in  1.
REQ-015 i_bvalid  in  1, i_bresp  in  2, o_bready  out  1  AXI write response channel.
REQ-016 o_idle  out  1  no command in progress and no outstanding bursts; o_err  out  1  sticky error flag.

Function
REQ-017 The FSM shall have three states: ST_IDLE, ST_AW, ST_W.
REQ-018 ST_IDLE: if i_brg_req=1 and outs_cnt<P_MAX_OUTS, assert o_brg_ack combinationally in that cycle, latch adrs/len, clear beat_cnt, and go to ST_AW.
REQ-019 o_brg_ack shall be 0 in every state other than ST_IDLE.
REQ-020 ST_AW: o_awvalid=1; on i_awready=1 go to ST_W. All AW fields shall be held stable while o_awvalid=1.
REQ-021 AW field encoding: o_awaddr = latched adrs shifted left 3 bits, zero-extended or truncated to 32 bits; o_awlen = len-1; o_awsize=3'd3; o_awburst=2'b01 (INCR).
REQ-022 A latched len of 0 shall be treated as 1 beat (o_awlen=0).
REQ-023 ST_W: o_wvalid=i_brg_wdvalid; o_wdata and o_wstrb pass through i_brg_wdata and i_brg_be combinationally; o_brg_wdack=i_brg_wdvalid & i_wready.
REQ-024 o_wvalid and o_brg_wdack shall be 0 outside ST_W.
REQ-025 o_wlast=1 when in ST_W and beat_cnt==len-1; beat_cnt shall increment on each W handshake.
REQ-026 A W handshake with o_wlast=1 shall return the FSM to ST_IDLE; a new command may be acked in the next cycle.
REQ-027 outs_cnt shall increment on each AW handshake, decrement on each B handshake, and remain unchanged when both occur in the same cycle.
REQ-028 outs_cnt shall never exceed P_MAX_OUTS; a B handshake while outs_cnt==0 shall be ignored.
REQ-029 o_bready shall be 1 whenever outs_cnt>0.
REQ-030 o_err shall be set on a B handshake with i_bresp!=2'b00 and cleared only by reset.
REQ-031 o_idle shall be 1 iff the FSM is in ST_IDLE and outs_cnt==0.

Reset
REQ-032 While rst=1, state=ST_IDLE, outs_cnt=0, beat_cnt=0, o_err=0, and latched adrs/len=0.
REQ-033 During reset: o_awvalid=0, o_wvalid=0, o_wlast=0, o_brg_ack=0, o_brg_wdack=0, o_bready=0, o_idle=1.
REQ-034 Reset asserted mid-burst shall abandon the burst immediately; no AXI signal shall remain asserted after the reset edge.

Verification
REQ-035 Single command adrs=0x200, len=4, awready=1, wready=1 -> awaddr=0x1000, awlen=3, four W beats, wlast on the 4th beat, o_idle=1 after bvalid.
REQ-036 awready held 0 for 5 cycles -> awvalid and all AW fields stable for 5 cycles; no W beat before the AW handshake.
REQ-037 wdvalid toggling and wready stalls for len=3 -> exactly 3 wdack pulses, wlast only on the 3rd beat.
REQ-038 Five back-to-back len=1 commands with bvalid held 0 -> 4 acked, 5th held with o_brg_ack=0 until the 1st bvalid handshake.
REQ-039 AW handshake and B handshake in the same cycle -> outs_cnt unchanged; bresp=2'b10 -> o_err=1 and sticky until rst.
REQ-040 rst pulse after the 2nd of 4 beats -> all outputs return to reset values; the next command runs a clean 4-beat burst.
